// File: rtl/dfr_sample_sequencer.sv
// Batch sequencer: runs num_samples DFR core passes per host command, stepping the
// input/output window addresses and guarding each core handshake with a timeout.
//
// state       | meaning
// S_IDLE      | waiting for a host start; config latched on accept
// S_LAUNCH    | dfr_start high for one cycle
// S_WAIT_ACK  | waiting for the core to raise dfr_busy
// S_WAIT_DONE | waiting for the core to drop dfr_busy
// S_NEXT      | last sample check; step index and addresses
// S_FINISH    | done pulse, back to idle
module dfr_sample_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  input  logic [ADDR_WIDTH-1:0] input_base_addr,
  input  logic [ADDR_WIDTH-1:0] input_stride,
  input  logic [ADDR_WIDTH-1:0] output_base_addr,
  input  logic [ADDR_WIDTH-1:0] output_stride,
  input  logic                  dfr_busy,
  output logic                  dfr_start,
  output logic [ADDR_WIDTH-1:0] dfr_input_addr,
  output logic [ADDR_WIDTH-1:0] dfr_output_addr,
  output logic [CNT_WIDTH-1:0]  sample_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  aborted
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_NEXT, S_FINISH
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [ADDR_WIDTH-1:0] in_stride_q, out_stride_q;
  logic [TW-1:0]         to_cnt;
  logic                  to_expired;
  logic                  load, advance, to_hit, abort_hit;

  assign to_expired = TO_EN && (to_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    dfr_start = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    to_hit    = 1'b0;
    abort_hit = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          state_nxt = (num_samples == '0) ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        dfr_start = 1'b1;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (dfr_busy) state_nxt = S_WAIT_DONE;
        else if (to_expired) begin
          to_hit    = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      S_WAIT_DONE: begin
        if (!dfr_busy) state_nxt = S_NEXT;
        else if (to_expired) begin
          to_hit    = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      S_NEXT: begin
        if (sample_idx == num_q - CNT_WIDTH'(1)) state_nxt = S_FINISH;
        else begin
          advance   = 1'b1;
          state_nxt = S_LAUNCH;
        end
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides any timeout or step decided above in the same cycle.
    if (abort && (state inside {S_LAUNCH, S_WAIT_ACK, S_WAIT_DONE, S_NEXT})) begin
      abort_hit = 1'b1;
      to_hit    = 1'b0;
      advance   = 1'b0;
      state_nxt = S_FINISH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      num_q           <= '0;
      in_stride_q     <= '0;
      out_stride_q    <= '0;
      dfr_input_addr  <= '0;
      dfr_output_addr <= '0;
      sample_idx      <= '0;
      to_cnt          <= '0;
      timeout_err     <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) to_cnt <= '0;
      else if (state == S_WAIT_ACK || state == S_WAIT_DONE) to_cnt <= to_cnt + 1'b1;

      if (load) begin
        num_q           <= num_samples;
        in_stride_q     <= input_stride;
        out_stride_q    <= output_stride;
        dfr_input_addr  <= input_base_addr;
        dfr_output_addr <= output_base_addr;
        sample_idx      <= '0;
        timeout_err     <= 1'b0;
        aborted         <= 1'b0;
      end else if (advance) begin
        sample_idx      <= sample_idx + 1'b1;
        dfr_input_addr  <= dfr_input_addr + in_stride_q;
        dfr_output_addr <= dfr_output_addr + out_stride_q;
      end

      if (to_hit)    timeout_err <= 1'b1;
      if (abort_hit) aborted     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dfr_sample_sequencer.sv
// Bench for dfr_sample_sequencer: directed and randomized batches against a
// cycle-arithmetic model of launch times, addresses and status flags.
module tb_dfr_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, dfr_busy;
  logic [15:0] num_samples;
  logic [31:0] input_base_addr, input_stride, output_base_addr, output_stride;
  logic        dfr_start, busy, done, timeout_err, aborted;
  logic [31:0] dfr_input_addr, dfr_output_addr;
  logic [15:0] sample_idx;

  logic        start2, abort2, dfr_busy2;
  logic        dfr_start2, busy2, done2, timeout_err2, aborted2;
  logic [31:0] in_addr2, out_addr2;
  logic [15:0] idx2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dfr_sample_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_samples(num_samples),
    .input_base_addr(input_base_addr), .input_stride(input_stride),
    .output_base_addr(output_base_addr), .output_stride(output_stride),
    .dfr_busy(dfr_busy), .dfr_start(dfr_start), .dfr_input_addr(dfr_input_addr),
    .dfr_output_addr(dfr_output_addr), .sample_idx(sample_idx), .busy(busy),
    .done(done), .timeout_err(timeout_err), .aborted(aborted)
  );

  dfr_sample_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .num_samples(num_samples),
    .input_base_addr(input_base_addr), .input_stride(input_stride),
    .output_base_addr(output_base_addr), .output_stride(output_stride),
    .dfr_busy(dfr_busy2), .dfr_start(dfr_start2), .dfr_input_addr(in_addr2),
    .dfr_output_addr(out_addr2), .sample_idx(idx2), .busy(busy2),
    .done(done2), .timeout_err(timeout_err2), .aborted(aborted2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one batch on the main instance. The core holds busy for blen cycles after
  // each launch; abort_cyc > 0 raises abort for that one cycle. Cycle 1 is the
  // cycle right after the start edge. A stray start with scrambled config is
  // pulsed at cycle 3 and must have no effect.
  task automatic run_batch(input int n, input logic [31:0] ib, input logic [31:0] istr,
                           input logic [31:0] ob, input logic [31:0] ostr,
                           input int blen, input int abort_cyc);
    int launches = 0;
    int rem = 0;
    int exp_l = 0;
    int exp_done;
    bit seen_done = 1'b0;
    logic [31:0] e_in, e_out;
    if (abort_cyc > 0) begin
      exp_done = abort_cyc + 1;
      for (int k = 0; k < n; k++) if (1 + k * (blen + 3) <= abort_cyc) exp_l++;
    end else begin
      exp_done = 1 + n * (blen + 3);
      exp_l    = n;
    end
    @(negedge clk);
    num_samples      = 16'(n);
    input_base_addr  = ib;
    input_stride     = istr;
    output_base_addr = ob;
    output_stride    = ostr;
    start    = 1'b1;
    abort    = 1'b0;
    dfr_busy = 1'b0;
    for (int cyc = 1; cyc <= exp_done + 4 && !seen_done; cyc++) begin
      @(negedge clk);
      start            = (cyc == 3);
      abort            = (cyc == abort_cyc);
      num_samples      = 16'($urandom);
      input_base_addr  = $urandom;
      input_stride     = $urandom;
      output_base_addr = $urandom;
      output_stride    = $urandom;
      if (dfr_start) begin
        e_in  = ib + 32'(launches) * istr;
        e_out = ob + 32'(launches) * ostr;
        check("launch_cycle", 64'(cyc), 64'(1 + launches * (blen + 3)));
        check("in_addr", 64'(dfr_input_addr), 64'(e_in));
        check("out_addr", 64'(dfr_output_addr), 64'(e_out));
        check("sample_idx", 64'(sample_idx), 64'(launches));
        launches++;
        rem      = blen;
        dfr_busy = 1'b0;
      end else if (rem > 0) begin
        dfr_busy = 1'b1;
        rem--;
      end else begin
        dfr_busy = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("launch_count", 64'(launches), 64'(exp_l));
        check("busy_at_done", 64'(busy), 64'(1));
        check("timeout_err", 64'(timeout_err), 64'(0));
        check("aborted", 64'(aborted), 64'(abort_cyc > 0));
      end
    end
    if (!seen_done) check("done_seen", 64'(0), 64'(1));
    start    = 1'b0;
    abort    = 1'b0;
    dfr_busy = 1'b0;
    @(negedge clk);
    check("busy_after_done", 64'(busy), 64'(0));
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  initial begin
    int cyc_done;
    int n, blen, nominal, ab;

    rst = 1'b1; start = 1'b0; abort = 1'b0; dfr_busy = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; dfr_busy2 = 1'b0;
    num_samples = '0; input_base_addr = '0; input_stride = '0;
    output_base_addr = '0; output_stride = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_dfr_start", 64'(dfr_start), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_addrs", 64'({dfr_input_addr, dfr_output_addr}), 64'(0));
    check("rst_idx", 64'(sample_idx), 64'(0));
    check("rst_flags", 64'({timeout_err, aborted}), 64'(0));
    rst = 1'b0;

    run_batch(3, 32'h1000, 32'h40, 32'h8000, 32'h10, 10, 0);
    run_batch(0, 32'h1234, 32'h4, 32'h5678, 32'h8, 3, 0);
    run_batch(2, 32'hFFFF_FFC0, 32'h40, 32'h0, 32'h100, 4, 0);
    run_batch(3, 32'h1000, 32'h40, 32'h8000, 32'h10, 10, 18);

    for (int it = 0; it < 8; it++) begin
      n       = $urandom_range(1, 4);
      blen    = $urandom_range(1, 6);
      nominal = 1 + n * (blen + 3);
      ab      = (it % 2 == 1) ? $urandom_range(3, nominal - 1) : 0;
      run_batch(n, $urandom, $urandom, $urandom, $urandom, blen, ab);
    end

    // Reset in the middle of the first pass's WAIT_DONE.
    @(negedge clk);
    num_samples = 16'd3; input_base_addr = 32'h1000; input_stride = 32'h40;
    output_base_addr = 32'h8000; output_stride = 32'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dfr_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_before_rst", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dfr_busy = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_start_done", 64'({dfr_start, done}), 64'(0));
    check("midrst_addrs", 64'({dfr_input_addr, dfr_output_addr}), 64'(0));
    check("midrst_idx", 64'(sample_idx), 64'(0));
    run_batch(2, 32'h2000, 32'h20, 32'h9000, 32'h8, 2, 0);

    // Timeout instance: core never answers, WAIT_ACK entered at cycle 2.
    @(negedge clk);
    num_samples = 16'd2; input_base_addr = 32'hA000; input_stride = 32'h40;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("to_launch", 64'(dfr_start2), 64'(1));
    cyc_done = 0;
    for (int cyc = 2; cyc <= 30 && cyc_done == 0; cyc++) begin
      @(negedge clk);
      if (dfr_start2) check("to_extra_launch", 64'(1), 64'(0));
      if (done2) cyc_done = cyc;
    end
    check("to_done_cycle", 64'(cyc_done), 64'(10));
    check("to_flag", 64'(timeout_err2), 64'(1));
    check("to_aborted", 64'(aborted2), 64'(0));
    @(negedge clk);
    check("to_sticky", 64'({busy2, timeout_err2}), 64'(1));
    num_samples = 16'd0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("to_cleared", 64'(timeout_err2), 64'(0));
    check("zero_done_busy", 64'({done2, busy2}), 64'(3));

    // Abort on the very cycle the timeout would fire.
    @(negedge clk);
    num_samples = 16'd1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc_done = 0;
    for (int cyc = 2; cyc <= 30 && cyc_done == 0; cyc++) begin
      @(negedge clk);
      abort2 = (cyc == 9);
      if (done2) cyc_done = cyc;
    end
    abort2 = 1'b0;
    check("ab_to_done_cycle", 64'(cyc_done), 64'(10));
    check("ab_to_aborted", 64'(aborted2), 64'(1));
    check("ab_to_timeout", 64'(timeout_err2), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dfr_sample_sequencer.md
# dfr_sample_sequencer

Batch sequencer that sits between the host register file and the DFR core controller. One host command runs `num_samples` back-to-back inference passes. For each pass the block presents per-sample input and output window addresses, pulses the core start, and waits for the core busy to rise and then fall. It guards each wait with a cycle timeout and reports done, timeout and abort status to the host.

## Interface
- `ADDR_WIDTH`, 32: width of base, stride and address ports.
- `CNT_WIDTH`, 16: width of sample count and sample index.
- `TIMEOUT_CYCLES`, 65535: maximum cycles per wait state. 0 disables the timeout.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: command strobe; sampled only in IDLE.
- `abort` in 1: level; terminates the batch from any non-IDLE state.
- `num_samples` in CNT_WIDTH: number of passes; latched at start.
- `input_base_addr`, `input_stride` in ADDR_WIDTH each: input window base address and per-sample increment; latched at start.
- `output_base_addr`, `output_stride` in ADDR_WIDTH each: output window base address and per-sample increment; latched at start.
- `dfr_busy` in 1: busy output of the DFR core controller.
- `dfr_start` out 1: one-cycle start pulse to the core.
- `dfr_input_addr`, `dfr_output_addr` out ADDR_WIDTH each: current sample's windows; registered.
- `sample_idx` out CNT_WIDTH: index of the current sample; registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of every accepted command.
- `timeout_err`, `aborted` out 1 each: sticky status; cleared when the next start is accepted.

## Operation
- States: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, NEXT, FINISH. `dfr_start`, `busy` and `done` are Moore decodes of the state register.
- IDLE, on `start`:
  - Latch config, clear `sample_idx`, `timeout_err` and `aborted`.
  - Load both address registers with their bases.
  - Go to LAUNCH, or to FINISH if `num_samples`==0 (no core launch).
- LAUNCH: `dfr_start`=1; go to WAIT_ACK.
- WAIT_ACK: wait for `dfr_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `dfr_busy`=0, then go to NEXT.
- Timeout counter:
  - Cleared on entry to WAIT_ACK and to WAIT_DONE; increments each cycle spent in those states.
  - If it reaches TIMEOUT_CYCLES-1 with the exit condition still false, set `timeout_err` and go to FINISH.
- NEXT:
  - If `sample_idx`==num_samples-1, go to FINISH.
  - Otherwise increment `sample_idx`, add the strides to both address registers, and go to LAUNCH.
  - Address addition is modulo 2^ADDR_WIDTH; wrap is silent.
- FINISH: `done`=1; go to IDLE. Address and index registers hold their last values.
- `abort`=1 in LAUNCH, WAIT_ACK, WAIT_DONE or NEXT: set `aborted` and go to FINISH.
  - If abort occurs in LAUNCH, `dfr_start` is still high that cycle.
  - Abort and timeout in the same cycle: abort wins; `timeout_err` stays 0.
- `start` outside IDLE is ignored. Latched config is immune to port changes during a batch.
- `rst` forces IDLE from any state, mid-batch included.
  - Reset values: all outputs 0, addresses 0, `sample_idx` 0, counter 0.

## Timing
- `start` sampled at edge t puts the block in LAUNCH and drives `dfr_start` high for cycle t+1 only.
- With the core raising `dfr_busy` the cycle after start and holding it for B cycles, one pass takes B+3 cycles, LAUNCH to LAUNCH.
- An N-sample batch produces exactly N `dfr_start` pulses and one `done`.
- Addresses and `sample_idx` are stable from LAUNCH through WAIT_DONE of each pass. They update on the NEXT→LAUNCH edge.
- `done` comes 1 cycle after the last NEXT. `busy` falls the cycle after `done`.
- `num_samples`=0: `done` at t+1, `busy` high for that single cycle.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entering the wait state.

## Test plan
- 3 samples, input base 0x1000 / stride 0x40, output base 0x8000 / stride 0x10, core model busy 10 cycles:
  - 3 `dfr_start` pulses.
  - Input addresses 0x1000, 0x1040, 0x1080; output addresses 0x8000, 0x8010, 0x8020.
  - `sample_idx` 0, 1, 2.
  - One `done`, 13 cycles between launches, no error flags.
- `num_samples`=0 → no `dfr_start`; `done` and `busy` high one cycle after `start`.
- TIMEOUT_CYCLES=8, core never raises busy:
  - `timeout_err`=1, `done` 8 cycles after WAIT_ACK entry.
  - Next accepted `start` clears `timeout_err`.
- Abort:
  - `abort` during the 2nd pass's WAIT_DONE → `aborted`=1, `done` next cycle, only 2 launches.
  - `abort` and timeout in the same cycle → `aborted`=1, `timeout_err`=0.
- Input base 0xFFFF_FFC0, stride 0x40, 2 samples → second input address 0x0000_0000. A `start` pulse mid-batch is ignored.
- `rst` asserted in WAIT_DONE → next cycle IDLE, all outputs 0; a fresh `start` then runs normally.
